// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the LSU memory port.
//   - funct3 width/sign encodings (RISC-V load/store)
//   - response error codes
//   - port FSM state type
//   - f3_legal(): which funct3 values are meaningful for a load or a store
package mem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_FAULT    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_RESP
   } state_t;

   // Stores have no unsigned variants; loads have no 011/11x encodings.
   function automatic logic f3_legal(input logic we, input logic [2:0] f3);
      if (we)
         return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane formatter.
//   funct3_i  access size / signedness
//   lane_i    byte offset within the word
//   wdata_i   right-aligned store data
//   rdata_i   raw read word from memory
//   be_o      store byte enables
//   wdata_o   lane-replicated store data
//   ldata_o   extracted and sign/zero-extended load value
module lsu_align
   import mem_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] ldata_o
);

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign ld_byte = rdata_i[{lane_i, 3'b000} +: 8];
   assign ld_half = rdata_i[{lane_i[1], 4'b0000} +: 16];

   // Replicating the data into every lane lets memory pick it up with
   // byte enables alone, independent of the offset.
   always_comb begin
      be_o    = 4'b1111;
      wdata_o = wdata_i;
      case (funct3_i[1:0])
         2'b00: begin
            be_o    = 4'b0001 << lane_i;
            wdata_o = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            be_o    = 4'b0011 << lane_i;
            wdata_o = {2{wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      ldata_o = rdata_i;
      case (funct3_i)
         F3_B:    ldata_o = {{24{ld_byte[7]}}, ld_byte};
         F3_BU:   ldata_o = {24'd0, ld_byte};
         F3_H:    ldata_o = {{16{ld_half[15]}}, ld_half};
         F3_HU:   ldata_o = {16'd0, ld_half};
         default: ldata_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit port between the MEM stage and data memory.
//   req_*   one load/store per valid/ready handshake (ready only in IDLE)
//   resp_*  one-cycle completion pulse with formatted data and error code
//   mem_*   request/grant/response interface to the memory window
// Accesses are range/alignment checked up front; errors never reach memory.
// A response that does not arrive within TIMEOUT cycles completes with
// ERR_TIMEOUT.
module lsu_mem_port
   import mem_pkg::*;
#(
   parameter int          ADDR_W   = 12,
   parameter logic [31:0] MEM_BASE = 32'h0000_0000,
   parameter int          TIMEOUT  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic [1:0]        resp_err,
   output logic              mem_req,
   input  logic              mem_gnt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_be,
   output logic [31:0]       mem_wdata,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata
);

   localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state_q, state_d;
   logic               we_q, we_d;
   logic [2:0]         f3_q, f3_d;
   logic [ADDR_W-1:0]  off_q, off_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [1:0]         err_q, err_d;
   logic [31:0]        rdata_q, rdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [31:0] off_full;
   logic        fault, misal;
   logic [3:0]  st_be;
   logic [31:0] st_wdata, ld_data;

   assign off_full = req_addr - MEM_BASE;
   // Anything above the window (including wrap below MEM_BASE) is a fault.
   assign fault = !f3_legal(req_we, req_funct3) || ((off_full >> ADDR_W) != 32'd0);
   assign misal = (((req_funct3 == F3_H) || (req_funct3 == F3_HU)) && req_addr[0]) ||
                  ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));

   lsu_align u_align (
      .funct3_i (f3_q),
      .lane_i   (off_q[1:0]),
      .wdata_i  (wdata_q),
      .rdata_i  (mem_rdata),
      .be_o     (st_be),
      .wdata_o  (st_wdata),
      .ldata_o  (ld_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         f3_q    <= 3'd0;
         off_q   <= '0;
         wdata_q <= 32'd0;
         err_q   <= ERR_OK;
         rdata_q <= 32'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      off_d   = off_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               f3_d    = req_funct3;
               off_d   = off_full[ADDR_W-1:0];
               wdata_d = req_wdata;
               cnt_d   = '0;
               rdata_d = 32'd0;
               if (fault) begin
                  err_d   = ERR_FAULT;
                  state_d = S_RESP;
               end else if (misal) begin
                  err_d   = ERR_MISALIGN;
                  state_d = S_RESP;
               end else begin
                  err_d   = ERR_OK;
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            // Timeout wins over a grant arriving in the final cycle.
            if (cnt_q == CNT_LAST) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (mem_gnt) state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            // A response in the last cycle still counts as completion.
            if (mem_rvalid) begin
               rdata_d = we_q ? 32'd0 : ld_data;
               state_d = S_RESP;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = ERR_TIMEOUT;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Memory-side outputs are forced to 0 outside REQ so nothing stale leaks.
   assign req_ready  = (state_q == S_IDLE);
   assign mem_req    = (state_q == S_REQ);
   assign mem_we     = mem_req && we_q;
   assign mem_addr   = mem_req ? {off_q[ADDR_W-1:2], 2'b00} : '0;
   assign mem_be     = mem_req ? (we_q ? st_be : 4'b1111) : 4'b0000;
   assign mem_wdata  = (mem_req && we_q) ? st_wdata : 32'd0;
   assign resp_valid = (state_q == S_RESP);
   assign resp_rdata = resp_valid ? rdata_q : 32'd0;
   assign resp_err   = resp_valid ? err_q : ERR_OK;

endmodule

// File: tb/tb_lsu_mem_port.sv
module tb_lsu_mem_port;
   import mem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'd0;
   logic [31:0] req_addr = 32'd0;
   logic [31:0] req_wdata = 32'd0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [1:0]  resp_err;
   logic        mem_req;
   logic        mem_gnt = 1'b0;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = 32'd0;

   always #5 clk = ~clk;

   lsu_mem_port #(.ADDR_W(12), .MEM_BASE(32'h0000_0000), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] exp_rdata;
      logic [1:0]  exp_err;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [11:0] exp_maddr;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic [1:0]  err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[$];

   function automatic vec_t mkv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] rdata,
                                input logic [31:0] exp_rdata, input logic [1:0] exp_err,
                                input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                                input logic [11:0] exp_maddr);
      vec_t v;
      v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_be = exp_be;
      v.exp_wdata = exp_wdata; v.exp_maddr = exp_maddr;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Drives one request and plays the memory side: grant after gnt_wait
   // REQ cycles, read response the cycle after the grant (if respond).
   task automatic do_txn(input vec_t v, input int gnt_wait, input bit respond);
      exp_t e, got;
      int   lat, reqcyc;
      bit   granted, gnext, saw_req, done;
      @(negedge clk);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_we = v.we; req_funct3 = v.f3;
      req_addr = v.addr; req_wdata = v.wdata;
      e.rdata = v.exp_rdata;
      e.err   = v.exp_err;
      if (v.exp_err == ERR_OK)           e.lat = 3 + gnt_wait;
      else if (v.exp_err == ERR_TIMEOUT) e.lat = 17;
      else                               e.lat = 1;
      sb.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 1; reqcyc = 0; granted = 0; gnext = 0; saw_req = 0; done = 0;
      while (!done && lat <= 40) begin
         if (resp_valid) begin
            done = 1;
            got = sb.pop_front();
            chk("resp_rdata", resp_rdata, got.rdata);
            chk("resp_err", {30'd0, resp_err}, {30'd0, got.err});
            chk("latency", lat, got.lat);
            chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
         end else begin
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (mem_req) begin
               saw_req = 1;
               chk("mem_addr", {20'd0, mem_addr}, {20'd0, v.exp_maddr});
               chk("mem_be", {28'd0, mem_be}, {28'd0, v.exp_be});
               chk("mem_we", {31'd0, mem_we}, {31'd0, v.we});
               chk("mem_wdata", mem_wdata, v.exp_wdata);
               if (reqcyc >= gnt_wait) begin
                  mem_gnt = 1'b1; gnext = 1;
               end
               reqcyc++;
            end else if (granted && respond) begin
               mem_rvalid = 1'b1; mem_rdata = v.rdata;
            end
            @(posedge clk); #1;
            granted = gnext;
            lat++;
         end
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL resp_seen actual=none required=resp_valid within 40 cycles");
         if (sb.size() > 0) void'(sb.pop_front());
      end else begin
         if (v.exp_err == ERR_MISALIGN || v.exp_err == ERR_FAULT)
            chk("no_mem_req_on_err", {31'd0, saw_req}, 32'd0);
         else
            chk("mem_req_seen", {31'd0, saw_req}, 32'd1);
      end
      @(posedge clk); #1;
      chk("resp_one_pulse", {31'd0, resp_valid}, 32'd0);
      chk("req_ready_after", {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      // {we, f3, addr, wdata, rdata, exp_rdata, exp_err, exp_be, exp_wdata, exp_maddr}
      vecs.push_back(mkv(0, F3_B,  32'h003, 32'h0, 32'h80FF_0000, 32'hFFFF_FF80, ERR_OK, 4'hF, 32'h0, 12'h000));
      vecs.push_back(mkv(0, F3_HU, 32'h002, 32'h0, 32'h80FF_0000, 32'h0000_80FF, ERR_OK, 4'hF, 32'h0, 12'h000));
      vecs.push_back(mkv(0, F3_H,  32'h002, 32'h0, 32'h80FF_0000, 32'hFFFF_80FF, ERR_OK, 4'hF, 32'h0, 12'h000));
      vecs.push_back(mkv(0, F3_BU, 32'h001, 32'h0, 32'h1234_5678, 32'h0000_0056, ERR_OK, 4'hF, 32'h0, 12'h000));
      vecs.push_back(mkv(0, F3_B,  32'h000, 32'h0, 32'h0000_00F0, 32'hFFFF_FFF0, ERR_OK, 4'hF, 32'h0, 12'h000));
      vecs.push_back(mkv(0, F3_W,  32'h008, 32'h0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, ERR_OK, 4'hF, 32'h0, 12'h008));
      vecs.push_back(mkv(0, F3_HU, 32'hFFE, 32'h0, 32'hABCD_0000, 32'h0000_ABCD, ERR_OK, 4'hF, 32'h0, 12'hFFC));
      vecs.push_back(mkv(1, F3_B,  32'h001, 32'h1234_56AB, 32'h5555_AAAA, 32'h0, ERR_OK, 4'b0010, 32'hABAB_ABAB, 12'h000));
      vecs.push_back(mkv(1, F3_H,  32'h002, 32'h0000_BEEF, 32'h5555_AAAA, 32'h0, ERR_OK, 4'b1100, 32'hBEEF_BEEF, 12'h000));
      vecs.push_back(mkv(1, F3_W,  32'h004, 32'hCAFE_F00D, 32'h5555_AAAA, 32'h0, ERR_OK, 4'b1111, 32'hCAFE_F00D, 12'h004));
      vecs.push_back(mkv(0, F3_W,  32'h002, 32'h0, 32'h0, 32'h0, ERR_MISALIGN, 4'h0, 32'h0, 12'h0));
      vecs.push_back(mkv(0, F3_H,  32'h001, 32'h0, 32'h0, 32'h0, ERR_MISALIGN, 4'h0, 32'h0, 12'h0));
      vecs.push_back(mkv(1, 3'b100, 32'h000, 32'h0, 32'h0, 32'h0, ERR_FAULT, 4'h0, 32'h0, 12'h0));
      vecs.push_back(mkv(0, F3_W,  32'h1000, 32'h0, 32'h0, 32'h0, ERR_FAULT, 4'h0, 32'h0, 12'h0));
      vecs.push_back(mkv(0, 3'b011, 32'h000, 32'h0, 32'h0, 32'h0, ERR_FAULT, 4'h0, 32'h0, 12'h0));
      vecs.push_back(mkv(0, F3_H,  32'h1001, 32'h0, 32'h0, 32'h0, ERR_FAULT, 4'h0, 32'h0, 12'h0));

      // Reset state
      #12;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_fields", {mem_we, 3'd0, mem_be, 12'd0, mem_addr}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      @(negedge clk); rst = 1'b0;

      foreach (vecs[i]) do_txn(vecs[i], 0, 1'b1);

      // Grant withheld for 5 cycles: request must hold steady.
      do_txn(mkv(0, F3_W, 32'h010, 32'h0, 32'h0BAD_F00D, 32'h0BAD_F00D, ERR_OK, 4'hF, 32'h0, 12'h010), 5, 1'b1);

      // Grant but no response: timeout.
      do_txn(mkv(0, F3_W, 32'h020, 32'h0, 32'h0, 32'h0, ERR_TIMEOUT, 4'hF, 32'h0, 12'h020), 0, 1'b0);

      // Stray response while idle is ignored.
      mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      for (int k = 0; k < 2; k++) begin
         @(posedge clk); #1;
         chk("stray_resp_valid", {31'd0, resp_valid}, 32'd0);
         chk("stray_req_ready", {31'd0, req_ready}, 32'd1);
         chk("stray_mem_req", {31'd0, mem_req}, 32'd0);
      end
      mem_rvalid = 1'b0;

      // Reset asserted while waiting for the response.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = 32'h000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_in_req", {31'd0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      @(posedge clk); #1;
      mem_gnt = 1'b0;
      chk("abort_in_wait", {31'd0, mem_req}, 32'd0);
      rst = 1'b1;
      #1;
      chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
      chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk); rst = 1'b0;
      do_txn(mkv(0, F3_W, 32'h000, 32'h0, 32'h0102_0304, 32'h0102_0304, ERR_OK, 4'hF, 32'h0, 12'h000), 0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Parametrised successor to the combinational load/store formatter.
- Sits between the MEM pipeline stage and the data-memory / bus port.
- Accepts one load or store per request handshake and performs byte-lane alignment, byte enables and sign/zero extension.
- Adds range/alignment checking, a request/grant/response protocol toward memory, and a response timeout.

Parameters:
- ADDR_W, 12: byte-address width of the data memory window.
- MEM_BASE, 32'h0000_0000: base byte address of the window; offset = req_addr - MEM_BASE.
- TIMEOUT, 16: max cycles from entering REQ to mem_rvalid before a timeout error; must be ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  formatted load data; 0 for stores and errors.
- resp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 timeout.
- mem_req  out  1  memory request.
- mem_gnt  in  1  memory accepted request this cycle.
- mem_we  out  1  write enable.
- mem_addr  out  ADDR_W  word-aligned byte offset; low 2 bits are 0.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_rvalid  in  1  response/ack; stores also ack with it.
- mem_rdata  in  32  read word.

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- Reset values: state IDLE; req_ready=1; every other output 0; timeout counter 0.
- Reset mid-transaction abandons the access; mem_req drops immediately. Memory must tolerate this.
- FSM: IDLE → REQ → WAIT → RESP → IDLE. Error path: IDLE → RESP.
- IDLE:
  - Accept on req_valid && req_ready. Latch we, funct3, offset and wdata.
  - Check 1, access fault: illegal funct3 (store with 1xx, load with 011/11x), or offset ≥ 2^ADDR_W.
  - Check 2, misaligned: H/HU with addr[0]≠0, or W with addr[1:0]≠0.
  - Priority: access fault > misaligned.
  - On any error: go to RESP with the code; mem_req is never asserted.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1; mem_addr, mem_be, mem_we, mem_wdata held stable until mem_gnt.
  - mem_gnt → WAIT.
- WAIT:
  - mem_req=0. mem_rvalid → capture formatted data and go to RESP.
  - mem_rvalid in the same cycle as mem_gnt (REQ) is not accepted. Memory must respond at least one cycle after the grant.
- Timeout:
  - Counter clears on accept and increments each cycle in REQ and WAIT.
  - When it reaches TIMEOUT-1 without completion: drop mem_req, go to RESP with err=11.
  - mem_rvalid outside WAIT is ignored.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. req_ready is low in RESP; no back-to-back accept.
- Latency with a zero-wait memory (gnt in the REQ cycle, rvalid the next cycle): resp_valid 3 cycles after the accept edge. Error responses: 1 cycle after accept.
- Store formatting, lane = offset[1:0]:
  - SB: be = 4'b0001 << lane; wdata = byte replicated ×4.
  - SH: be = 4'b0011 << lane; wdata = half replicated ×2.
  - SW: be = 4'b1111; wdata = req_wdata.
- Load formatting:
  - mem_be = 4'b1111 for all loads.
  - B/BU: byte = rdata[8*lane+:8].
  - H/HU: half = rdata[16*offset[1]+:16].
  - B/H sign-extend from the top bit; BU/HU zero-extend; W passes through.
- All outputs driven from registered state and latched fields; no X is ever driven.

Decomposition:
- Package mem_pkg holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - Error codes: ERR_OK, ERR_MISALIGN, ERR_FAULT, ERR_TIMEOUT.
  - FSM state enum: state_t.
- One combinational sub-module, lsu_align: inputs funct3, lane, wdata and rdata; outputs be, mem_wdata and the extended load value. It is unit-tested standalone.

Test Plan:
- Zero-wait memory:
  - LB at 0x003, rdata=0x80FF_0000 → resp_rdata=0xFFFF_FF80, err=00, resp_valid 3 cycles after accept.
  - LHU at 0x002, same rdata → 0x0000_80FF.
- SB at 0x001, wdata=0x1234_56AB → mem_be=0010, mem_wdata=0xABAB_ABAB, mem_we=1. SW at 0x004 → be=1111, mem_addr=0x004.
- Errors, no mem_req ever asserted, resp_valid 1 cycle after accept:
  - LW at 0x002 → err=01.
  - Store with funct3=100 → err=10.
  - Address MEM_BASE+0x1000 with ADDR_W=12 → err=10.
- mem_gnt held low 5 cycles → mem_req and address stable throughout; completes normally after grant.
- mem_rvalid never returned, TIMEOUT=16 → err=11 exactly 16 cycles after entering REQ. A later stray mem_rvalid in IDLE has no effect.
- Assert rst in WAIT → mem_req/resp_valid 0 immediately, req_ready=1. The next LW at 0x000 completes correctly.
